// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter and sequencer for the single data memory.
// Latches the round-robin winner, holds it on the memory port for LATENCY cycles, then pulses done.
module dmem_arbiter #(
  parameter int LATENCY = 2,
  parameter int XFER    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic        cpu_done,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  output logic        dma_done,
  output logic [63:0] dma_rdata,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);

  // Handshake: a port raises req and holds it (with we/addr/wdata) until its done pulses for one
  // cycle; done means the access finished and, for a read, rdata already holds the result.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        last_grant, last_grant_next;  // 1 = DMA
  logic        winner, winner_next;          // 1 = DMA
  logic        we_q, we_next;
  logic [63:0] addr_q, addr_next;
  logic [63:0] wdata_q, wdata_next;
  logic [63:0] cpu_rdata_next, dma_rdata_next;
  logic        pick_dma;

  // DMA wins when alone, or on a tie when the CPU was granted last.
  assign pick_dma = dma_req & (~cpu_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      cpu_rdata  <= 64'd0;
      dma_rdata  <= 64'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_grant <= last_grant_next;
      winner     <= winner_next;
      we_q       <= we_next;
      addr_q     <= addr_next;
      wdata_q    <= wdata_next;
      cpu_rdata  <= cpu_rdata_next;
      dma_rdata  <= dma_rdata_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    winner_next     = winner;
    we_next         = we_q;
    addr_next       = addr_q;
    wdata_next      = wdata_q;
    cpu_rdata_next  = cpu_rdata;
    dma_rdata_next  = dma_rdata;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          winner_next = pick_dma;
          we_next     = pick_dma ? dma_we    : cpu_we;
          addr_next   = pick_dma ? dma_addr  : cpu_addr;
          wdata_next  = pick_dma ? dma_wdata : cpu_wdata;
          cnt_next    = CNT_LOAD;
          state_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          if (!we_q) begin
            if (winner) dma_rdata_next = mem_read_data;
            else        cpu_rdata_next = mem_read_data;
          end
          last_grant_next = winner;
          state_next      = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port is decoded from registered state only; nothing here depends on the req inputs.
  assign mem_address      = (state == ACCESS) ? addr_q  : 64'd0;
  assign mem_write_data   = (state == ACCESS) ? wdata_q : 64'd0;
  assign mem_read_enable  = (state == ACCESS) & ~we_q;
  assign mem_write_enable = (state == ACCESS) & we_q & (cnt == 4'd0);
  assign mem_xfer_size    = 4'(XFER);

  assign cpu_done  = (state == DONE) & ~winner;
  assign dma_done  = (state == DONE) &  winner;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule
